// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame geometry,
// common to the receiver and transmitter.
package uart_pkg;

  localparam int unsigned WIDTH_DATA_DEF = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line, oversampling strobe, read strobe and the
// buffered word with its status flags.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF
) ();

  logic                  i_tick;
  logic                  i_rx;
  logic                  i_re;
  logic [WIDTH_DATA-1:0] o_data;
  logic                  o_rdy;
  logic                  o_ferr;
  logic                  o_ovr;
  logic                  o_perr;

  modport master (
    output i_tick, i_rx, i_re,
    input  o_data, o_rdy, o_ferr, o_ovr, o_perr
  );

  modport slave (
    input  i_tick, i_rx, i_re,
    output o_data, o_rdy, o_ferr, o_ovr, o_perr
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable
// so an idle-high line does not look like a start bit out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a one-word buffer and sticky error flags.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  uart_rx_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;

  uart_state_t             state, state_next;
  logic [CNT_W-1:0]        tick_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [WIDTH_DATA-1:0]   shift;
  logic [WIDTH_DATA-1:0]   data;
  logic [WIDTH_DATA:0]     shift_in_c;
  logic                    rdy, ferr, ovr;
  logic                    rx_s;
  logic                    tick_half, tick_last, bit_last;
  logic                    cnt_clr_c, cnt_inc_c, bit_clr_c, shift_c, stop_c;
`ifdef UART_RX_PARITY_EN
  logic                    par_c, perr_pend, perr;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (bus.i_rx),
    .q   (rx_s)
  );

  assign tick_half  = (tick_cnt == CNT_W'(OVERSAMPLE / 2 - 1));
  assign tick_last  = (tick_cnt == CNT_W'(OVERSAMPLE - 1));
  assign bit_last   = (bit_cnt == BIT_W'(WIDTH_DATA - 1));
  assign shift_in_c = {rx_s, shift};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (bus.i_tick && !rx_s) state_next = ST_START;
      ST_START: if (bus.i_tick && tick_half) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (bus.i_tick && tick_last && bit_last) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bus.i_tick && tick_last) state_next = ST_STOP;
`endif
      ST_STOP:  if (bus.i_tick && tick_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Counter and sampling strobes; every action is gated by the tick.
  always_comb begin
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;
    bit_clr_c = 1'b0;
    shift_c   = 1'b0;
    stop_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_c     = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        bit_clr_c = 1'b1;
        cnt_clr_c = bus.i_tick;
      end
      ST_START: begin
        cnt_clr_c = bus.i_tick && tick_half;
        cnt_inc_c = bus.i_tick && !tick_half;
      end
      ST_DATA: begin
        cnt_clr_c = bus.i_tick && tick_last;
        cnt_inc_c = bus.i_tick && !tick_last;
        shift_c   = bus.i_tick && tick_last;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        cnt_clr_c = bus.i_tick && tick_last;
        cnt_inc_c = bus.i_tick && !tick_last;
        par_c     = bus.i_tick && tick_last;
      end
`endif
      ST_STOP: begin
        cnt_clr_c = bus.i_tick && tick_last;
        cnt_inc_c = bus.i_tick && !tick_last;
        stop_c    = bus.i_tick && tick_last;
      end
      default: bit_clr_c = 1'b1;
    endcase
  end

  // Datapath and buffer; a stop-bit event is applied after the read clear so it wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      ferr      <= 1'b0;
      ovr       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend <= 1'b0;
      perr      <= 1'b0;
`endif
    end else begin
      if (cnt_clr_c)      tick_cnt <= '0;
      else if (cnt_inc_c) tick_cnt <= tick_cnt + CNT_W'(1);
      if (bit_clr_c)      bit_cnt <= '0;
      else if (shift_c)   bit_cnt <= bit_cnt + BIT_W'(1);
      if (shift_c)        shift <= shift_in_c[WIDTH_DATA:1];
`ifdef UART_RX_PARITY_EN
      if (par_c)          perr_pend <= ^shift_in_c;
`endif
      if (bus.i_re) begin
        rdy  <= 1'b0;
        ferr <= 1'b0;
        ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr <= 1'b0;
`endif
      end
      if (stop_c) begin
        if (!rx_s) begin
          ferr <= 1'b1;
        end else if (rdy && !bus.i_re) begin
          ovr <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (!perr_pend) begin
`else
        end else begin
`endif
          data <= shift;
          rdy  <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        if (perr_pend) perr <= 1'b1;
`endif
      end
    end
  end

  assign bus.o_data = data;
  assign bus.o_rdy  = rdy;
  assign bus.o_ferr = ferr;
  assign bus.o_ovr  = ovr;
`ifdef UART_RX_PARITY_EN
  assign bus.o_perr = perr;
`else
  assign bus.o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit with i_tick every cycle,
// buffer and flags compared against hand-computed values.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned WD = 8;
  localparam int unsigned OS = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_rx_if #(.WIDTH_DATA(WD)) bus ();

  uart_rx #(.WIDTH_DATA(WD), .OVERSAMPLE(OS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold_bit(input logic v, input int n);
    bus.i_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold_bit(1'b1, n);
  endtask

  // Drive n bits LSB first, each one bit period long.
  task automatic send_raw(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) hold_bit(bits[i], OS);
    bus.i_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_raw({1'b0, stop, ^d, d, 1'b0}, 11);
`else
    send_raw({2'b00, stop, d, 1'b0}, 10);
`endif
  endtask

  task automatic pulse_re;
    bus.i_re = 1'b1;
    @(posedge clk);
    #1;
    bus.i_re = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    bus.i_rx   = 1'b1;
    bus.i_tick = 1'b1;
    bus.i_re   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(bus.o_data), 32'h00);
    check("rst_rdy",  32'(bus.o_rdy),  32'h0);
    check("rst_ferr", 32'(bus.o_ferr), 32'h0);
    check("rst_ovr",  32'(bus.o_ovr),  32'h0);
    check("rst_perr", 32'(bus.o_perr), 32'h0);
    rst = 1'b0;
    idle(5);

    // Clean frame
    send_frame(8'hA5, 1'b1);
    idle(4);
    check("a5_data", 32'(bus.o_data), 32'hA5);
    check("a5_rdy",  32'(bus.o_rdy),  32'h1);
    check("a5_ferr", 32'(bus.o_ferr), 32'h0);
    check("a5_ovr",  32'(bus.o_ovr),  32'h0);
    check("a5_perr", 32'(bus.o_perr), 32'h0);
    pulse_re();
    check("a5_re_rdy", 32'(bus.o_rdy), 32'h0);

    // Start-bit glitch
    hold_bit(1'b0, 4);
    idle(40);
    check("gl_rdy",  32'(bus.o_rdy),  32'h0);
    check("gl_ferr", 32'(bus.o_ferr), 32'h0);
    check("gl_ovr",  32'(bus.o_ovr),  32'h0);

    // Framing error
    send_frame(8'h3C, 1'b0);
    idle(40);
    check("fe_ferr", 32'(bus.o_ferr), 32'h1);
    check("fe_rdy",  32'(bus.o_rdy),  32'h0);
    check("fe_data", 32'(bus.o_data), 32'hA5);
    pulse_re();
    check("fe_re_ferr", 32'(bus.o_ferr), 32'h0);

    // Back-to-back overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("ov_data", 32'(bus.o_data), 32'h11);
    check("ov_ovr",  32'(bus.o_ovr),  32'h1);
    check("ov_rdy",  32'(bus.o_rdy),  32'h1);
    pulse_re();
    check("ov_re_rdy", 32'(bus.o_rdy), 32'h0);
    check("ov_re_ovr", 32'(bus.o_ovr), 32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1
    send_raw({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(4);
    check("pe_perr", 32'(bus.o_perr), 32'h1);
    check("pe_rdy",  32'(bus.o_rdy),  32'h0);
    pulse_re();
    send_raw({1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(4);
    check("pok_data", 32'(bus.o_data), 32'h07);
    check("pok_rdy",  32'(bus.o_rdy),  32'h1);
    check("pok_perr", 32'(bus.o_perr), 32'h0);
    pulse_re();
`endif

    // Reset during bit 3 of 0xFF, then a clean frame
    hold_bit(1'b0, OS);
    for (int i = 0; i < 3; i++) hold_bit(1'b1, OS);
    hold_bit(1'b1, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(OS * 8);
    check("mr_rdy",  32'(bus.o_rdy),  32'h0);
    check("mr_data", 32'(bus.o_data), 32'h00);
    send_frame(8'h5A, 1'b1);
    idle(4);
    check("mr_5a_data", 32'(bus.o_data), 32'h5A);
    check("mr_5a_rdy",  32'(bus.o_rdy),  32'h1);
    check("mr_5a_ferr", 32'(bus.o_ferr), 32'h0);
    check("mr_5a_ovr",  32'(bus.o_ovr),  32'h0);
    check("mr_5a_perr", 32'(bus.o_perr), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 8: number of data bits per frame, LSB first.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: i_tick pulses per bit period; even, >= 4.
REQ-003 SHALL have port i_clk, input, 1: sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_tick, input, 1: one-cycle oversampling strobe from clock_gen, OVERSAMPLE per bit.
REQ-006 SHALL have port i_rx, input, 1: asynchronous serial line, idle high.
REQ-007 SHALL have port i_re, input, 1: read strobe that consumes the buffered word.
REQ-008 SHALL have port o_data, output, WIDTH_DATA: last accepted word.
REQ-009 SHALL have port o_rdy, output, 1: o_data holds an unread word.
REQ-010 SHALL have port o_ferr, output, 1: sticky framing error.
REQ-011 SHALL have port o_ovr, output, 1: sticky overrun.
REQ-012 SHALL have port o_perr, output, 1: sticky parity error.

Function
REQ-013 SHALL pass i_rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s), 2 cycles of latency.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; tick counter and bit counter advance only on cycles with i_tick=1.
REQ-015 IDLE: on a tick with rx_s=0, SHALL go to START and clear the tick counter.
REQ-016 START: after OVERSAMPLE/2 ticks, SHALL sample rx_s; if 1 (glitch), return to IDLE with no flags; if 0, go to DATA.
REQ-017 DATA: SHALL sample every OVERSAMPLE ticks (bit centre), shifting LSB first; after WIDTH_DATA samples, go to PARITY if enabled, else STOP.
REQ-018 STOP: SHALL sample after OVERSAMPLE ticks, then return to IDLE on the same tick, so back-to-back frames with a single stop bit are received.
REQ-019 Stop sample 1, o_rdy=0: SHALL load o_data and set o_rdy on the next cycle.
REQ-020 Stop sample 1, o_rdy=1 and i_re=0: SHALL discard the new word, keep o_data, and set o_ovr.
REQ-021 Stop sample 0: SHALL discard the word, set o_ferr, leave o_rdy unchanged.
REQ-022 i_re=1 with o_rdy=1: SHALL clear o_rdy, o_ferr, o_ovr and o_perr next cycle; i_re with o_rdy=0 clears flags only.
REQ-023 i_re coinciding with a successful stop sample SHALL load the new word and keep o_rdy=1; no overrun.
REQ-024 i_tick SHALL be ignored while i_tick=0; the FSM holds state between ticks.

Reset
REQ-025 i_rst=1 SHALL force state IDLE, both counters 0, synchronizer flops 1, o_data 0, o_rdy 0, o_ferr 0, o_ovr 0, o_perr 0, with priority over all inputs.
REQ-026 Reset mid-frame SHALL abandon the frame; the next falling edge after release starts a fresh frame.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, SHALL receive one even-parity bit after the data bits (PARITY state, centre sampled); on mismatch set o_perr and discard the word, with o_ferr/o_ovr still evaluated at STOP.
REQ-028 Without UART_RX_PARITY_EN, SHALL omit the PARITY state and parity logic, and tie o_perr to 0.

Structure
REQ-029 Shared package uart_pkg SHALL hold FSM state encodings and default WIDTH_DATA/OVERSAMPLE constants, shared with tx.
REQ-030 The synchronizer SHALL be a separate sub-module, sync2, 1 bit wide, reset value parameterizable (1 here).

Verification
REQ-031 With WIDTH_DATA=8, OVERSAMPLE=16 and i_tick=1 every cycle, frame 0xA5 at 16 clocks/bit -> o_data=0xA5, o_rdy=1, no error flags.
REQ-032 i_rx low for 4 ticks, then high -> FSM returns to IDLE; o_rdy, o_ferr and o_ovr stay 0.
REQ-033 Frame 0x3C with stop bit driven 0 -> o_ferr=1, o_rdy=0, o_data unchanged.
REQ-034 Frames 0x11 then 0x22 back-to-back, no i_re -> o_data=0x11, o_ovr=1; one-cycle i_re then clears o_rdy and o_ovr.
REQ-035 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> o_perr=1, o_rdy=0; same frame with parity bit 1 -> o_data=0x07.
REQ-036 i_rst pulsed during bit 3 of 0xFF, then a clean frame 0x5A -> o_data=0x5A, o_rdy=1, no flags.
